ir_tx_module: RTL and testbench

IR_TX_MODULE -- requirements
Module: ir_tx_module

---
 rtl/ir_pkg.sv | 44 ++++
 rtl/ir_carrier.sv | 35 +++
 rtl/ir_tx_module.sv | 102 ++++++++++
 tb/tb_ir_tx_module.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: FSM encoding and frame timing in 1 us clk cycles.
// Imported by the transmitter and the IR receiver.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5
    } ir_state_t;

    localparam int DUR_W     = 14;
    localparam int BIT_CNT_W = 6;
    localparam int CAR_CNT_W = 5;

    localparam logic [DUR_W-1:0] LEAD_MARK_CYC  = 14'd9000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_CYC = 14'd4500;
    localparam logic [DUR_W-1:0] BIT_MARK_CYC   = 14'd560;
    localparam logic [DUR_W-1:0] ZERO_SPACE_CYC = 14'd560;
    localparam logic [DUR_W-1:0] ONE_SPACE_CYC  = 14'd1690;
    localparam logic [DUR_W-1:0] STOP_MARK_CYC  = 14'd560;
    localparam int               FRAME_BITS     = 32;

    function automatic logic is_mark(input ir_state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

    // IDLE has no timed exit; 1 keeps the terminal-count compare from underflowing.
    function automatic logic [DUR_W-1:0] state_duration(input ir_state_t s, input logic bit_val);
        logic [DUR_W-1:0] d;
        case (s)
            ST_LEAD_MARK:  d = LEAD_MARK_CYC;
            ST_LEAD_SPACE: d = LEAD_SPACE_CYC;
            ST_BIT_MARK:   d = BIT_MARK_CYC;
            ST_BIT_SPACE:  d = bit_val ? ONE_SPACE_CYC : ZERO_SPACE_CYC;
            ST_STOP_MARK:  d = STOP_MARK_CYC;
            default:       d = 14'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ir_carrier.sv
// IR carrier generator: square wave starting high, held at 0 while disabled.
// enable is the envelope of the coming cycle, so carrier lines up with a registered envelope.
module ir_carrier #(
    parameter int CARRIER_HALF = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic carrier
);
    import ir_pkg::*;

    localparam logic [CAR_CNT_W-1:0] HALF = CAR_CNT_W'(CARRIER_HALF);
    localparam logic [CAR_CNT_W-1:0] LAST = CAR_CNT_W'(2 * CARRIER_HALF - 1);

    logic [CAR_CNT_W-1:0] r_cnt;
    logic                 r_carrier;

    // Holding the phase at 0 while disabled restarts every mark high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end else if (!enable) begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end else begin
            r_carrier <= (r_cnt < HALF);
            r_cnt     <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign carrier = r_carrier;

endmodule

// File: rtl/ir_tx_module.sv
// NEC IR transmitter: leader, 32 payload bits LSB first, stop mark.
// Handshake: start is taken only when busy=0 (including the done cycle); addr/code are captured on that edge.
module ir_tx_module
    import ir_pkg::*;
#(
    parameter int CARRIER_HALF = 13,
    parameter int CARRIER_EN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] code,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_out,
    output ir_state_t  o_state
);

    ir_state_t              r_state;
    ir_state_t              w_next_state;
    logic [DUR_W-1:0]       r_dur_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_env;
    logic                   r_busy;
    logic                   r_done;
    logic [DUR_W-1:0]       w_dur;
    logic                   w_term;
    logic                   w_accept;
    logic                   w_last_bit;
    logic                   w_env_next;
    logic                   w_carrier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_dur        = state_duration(r_state, r_shift[0]);
        w_term       = (r_dur_cnt == (w_dur - 14'd1));
        w_accept     = (r_state == ST_IDLE) && start;
        w_last_bit   = (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
        case (r_state)
            ST_IDLE:       if (start)  w_next_state = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (w_term) w_next_state = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (w_term) w_next_state = ST_BIT_MARK;
            ST_BIT_MARK:   if (w_term) w_next_state = ST_BIT_SPACE;
            ST_BIT_SPACE:  if (w_term) w_next_state = w_last_bit ? ST_STOP_MARK : ST_BIT_MARK;
            ST_STOP_MARK:  if (w_term) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
        w_env_next = is_mark(w_next_state);
    end

    // Outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dur_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_env     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_env  <= w_env_next;
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (r_state == ST_STOP_MARK) && w_term;

            if (w_next_state != r_state)  r_dur_cnt <= '0;
            else if (r_state != ST_IDLE)  r_dur_cnt <= r_dur_cnt + 1'b1;

            if (w_accept) begin
                r_shift   <= {~code, code, ~addr, addr};
                r_bit_cnt <= '0;
            end else if ((r_state == ST_BIT_SPACE) && w_term) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    ir_carrier #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_env_next),
        .carrier(w_carrier)
    );

    // The carrier is already forced low outside marks, so it is the gated LED drive.
    assign ir_out  = (CARRIER_EN != 0) ? w_carrier : r_env;
    assign ir_env  = r_env;
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_ir_tx_module.sv
// Bench for ir_tx_module: per-cycle comparison against a segment-list NEC model,
// plus a width-based decode of the transmitted envelope.
module tb_ir_tx_module;
    import ir_pkg::*;

    localparam int CARRIER_HALF = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] addr;
    logic [7:0] code;
    logic       busy, done, ir_env, ir_out;
    logic       busy_nc, done_nc, ir_env_nc, ir_out_nc;
    ir_state_t  state_c, state_nc;

    int n_vec = 0;
    int n_err = 0;

    // Reference frame as a list of (level, length) segments.
    bit   seg_lvl[$];
    int   seg_len[$];
    int   total;
    logic [7:0] exp_q[$];
    int   run_len[$];

    always #5 clk = ~clk;

    ir_tx_module #(.CARRIER_HALF(CARRIER_HALF), .CARRIER_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .code(code),
        .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out), .o_state(state_c)
    );

    ir_tx_module #(.CARRIER_HALF(CARRIER_HALF), .CARRIER_EN(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .code(code),
        .busy(busy_nc), .done(done_nc), .ir_env(ir_env_nc), .ir_out(ir_out_nc), .o_state(state_nc)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] payload;
        payload = {~c, c, ~a, a};
        seg_lvl.delete();
        seg_len.delete();
        seg_lvl.push_back(1'b1); seg_len.push_back(9000);
        seg_lvl.push_back(1'b0); seg_len.push_back(4500);
        for (int i = 0; i < 32; i++) begin
            seg_lvl.push_back(1'b1); seg_len.push_back(560);
            seg_lvl.push_back(1'b0); seg_len.push_back(payload[i] ? 1690 : 560);
        end
        seg_lvl.push_back(1'b1); seg_len.push_back(560);
        total = 0;
        foreach (seg_len[i]) total += seg_len[i];
    endtask

    // t = cycles since the accepting edge (1 = first busy cycle).
    task automatic model_at(input int t, output bit env, output bit car);
        int acc;
        acc = 0;
        env = 1'b0;
        car = 1'b0;
        for (int i = 0; i < seg_len.size(); i++) begin
            if (t > acc && t <= acc + seg_len[i]) begin
                env = seg_lvl[i];
                car = env && (((t - acc - 1) % (2 * CARRIER_HALF)) < CARRIER_HALF);
            end
            acc += seg_len[i];
        end
    endtask

    task automatic check_cycle(input int t);
        bit e, c;
        model_at(t, e, c);
        check_value("ir_env", ir_env, e);
        check_value("ir_out", ir_out, c);
        check_value("busy", busy, (t >= 1 && t <= total));
        check_value("done", done, (t == total + 1));
        check_value("ir_env_nocar", ir_env_nc, e);
        check_value("ir_out_nocar", ir_out_nc, e);
    endtask

    task automatic check_all_low(input string tag);
        check_value({tag, "_busy"}, busy, 0);
        check_value({tag, "_done"}, done, 0);
        check_value({tag, "_env"}, ir_env, 0);
        check_value({tag, "_out"}, ir_out, 0);
        check_value({tag, "_state"}, 32'(state_c), 32'(ST_IDLE));
        check_value({tag, "_out_nocar"}, ir_out_nc, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] nb_a, nb_c, nc_a, nc_c;
        logic [31:0] word;
        int busy_cnt, cur_len, lb;
        bit cur_lvl;

        rst_n = 1'b0; start = 1'b0; addr = '0; code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_low("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_low("idle");

        // Frame A: fixed payload, noisy addr/code and an ignored start mid-frame.
        build_frame(8'h00, 8'h45);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h45); exp_q.push_back(8'hBA);
        nb_a = 8'($urandom); nb_c = 8'($urandom);
        start = 1'b1; addr = 8'h00; code = 8'h45;
        busy_cnt = 0; cur_len = 0; cur_lvl = 1'b1;
        for (int t = 1; t <= total + 1; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(t);
            if (busy) busy_cnt++;
            if (t <= total) begin
                if (t == 1) begin
                    cur_lvl = ir_env; cur_len = 1;
                end else if (ir_env == cur_lvl) begin
                    cur_len++;
                end else begin
                    run_len.push_back(cur_len);
                    cur_lvl = ir_env; cur_len = 1;
                end
                if (t == total) run_len.push_back(cur_len);
            end
            if (t == total + 1) begin
                start = 1'b1; addr = nb_a; code = nb_c;
            end else begin
                start = (t + 1 == 20000);
                addr  = 8'($urandom);
                code  = (t + 1 == 20000) ? 8'h12 : 8'($urandom);
            end
        end
        check_value("busy_len", busy_cnt, 67980);

        check_value("run_count", run_len.size(), 67);
        if (run_len.size() == 67) begin
            for (int b = 0; b < 32; b++) word[b] = (run_len[3 + 2 * b] > 1000);
            for (int k = 0; k < 4; k++) check_value("decoded_byte", word[8 * k +: 8], exp_q.pop_front());
        end

        // Frame B: back-to-back from the done cycle, then aborted by reset.
        build_frame(nb_a, nb_c);
        lb = $urandom_range(2000, 5000);
        for (int t = 1; t <= lb; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(t);
            start = 1'b0;
            addr  = 8'($urandom);
            code  = 8'($urandom);
        end
        #2 rst_n = 1'b0;
        #1 check_all_low("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_low("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_low("post_reset");

        // Frame C: fresh frame after reset, checked through leader and first bits.
        nc_a = 8'($urandom); nc_c = 8'($urandom);
        build_frame(nc_a, nc_c);
        start = 1'b1; addr = nc_a; code = nc_c;
        for (int t = 1; t <= 14200; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(t);
            start = 1'b0;
            addr  = 8'($urandom);
            code  = 8'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
